// File: rtl/permutation_pkg.sv
// Shared sizes and types for the permutation host: slice geometry, index widths,
// and the host FSM state encoding.
package permutation_pkg;

  localparam int SLICE_W = 25;
  localparam int DEPTH   = 64;
  localparam int IDX_W   = $clog2(DEPTH);

  typedef logic [SLICE_W-1:0] slice_t;
  typedef logic [IDX_W:0]     idx_t;
  typedef logic [IDX_W-1:0]   addr_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} host_state_t;

  // Indices carry one extra bit so DEPTH itself is a terminal, non-wrapping value.
  localparam idx_t IDX_LAST = idx_t'(DEPTH - 1);
  localparam idx_t IDX_FULL = idx_t'(DEPTH);

endpackage

// File: rtl/permutation_host_if.sv
// Load, core slice-stream and unload signals of the permutation host.
// master = the host, slave = the system/core side.
interface permutation_host_if;
  import permutation_pkg::*;

  logic   ld_valid;
  slice_t ld_data;
  logic   ld_ready;

  logic   perm_start;
  logic   perm_read;
  slice_t perm_in;
  logic   perm_ready;
  slice_t perm_out;
  logic   perm_total_ready;

  logic   ul_valid;
  slice_t ul_data;
  logic   ul_ready;

  logic   done;
  logic   err_overrun;
  logic   err_short;

  modport master (
    input  ld_valid, ld_data, perm_read, perm_ready, perm_out, perm_total_ready, ul_ready,
    output ld_ready, perm_start, perm_in, ul_valid, ul_data, done, err_overrun, err_short
  );

  modport slave (
    output ld_valid, ld_data, perm_read, perm_ready, perm_out, perm_total_ready, ul_ready,
    input  ld_ready, perm_start, perm_in, ul_valid, ul_data, done, err_overrun, err_short
  );

endinterface

// File: rtl/permutation_host_slice_buffer.sv
// DEPTH x SLICE_W slice store: one synchronous write port, one asynchronous read port.
module slice_buffer
  import permutation_pkg::*;
(
  input  logic   clk,
  input  logic   we,
  input  addr_t  waddr,
  input  slice_t wdata,
  input  addr_t  raddr,
  output slice_t rdata
);

  slice_t mem [DEPTH];

  // NOTE: storage is deliberately left out of reset; contents are always rewritten
  // before being read, and a resettable array would not map onto RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/permutation_host.sv
// Host side of the permutation slice stream: loads a 64-slice state, feeds it to the
// core on demand, captures the permuted slices, then streams them back out.
module permutation_host
  import permutation_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  permutation_host_if.master  bus
);

  host_state_t state;
  idx_t        ld_idx, rd_idx, wr_idx, ul_idx;
  slice_t      src_rdata, dst_rdata;
  addr_t       ul_raddr;
  logic        ld_fire, rd_fire, wr_fire, ul_fire;

  assign ld_fire = bus.ld_valid && bus.ld_ready;
  assign rd_fire = (state == RUN) && bus.perm_read && (rd_idx != IDX_FULL);
  assign wr_fire = (state == RUN) && bus.perm_ready;
  assign ul_fire = bus.ul_valid && bus.ul_ready;

  // Look one slice ahead while unloading so ul_data can be registered on each handshake.
  assign ul_raddr = ul_idx[IDX_W-1:0] + addr_t'(state == UNLOAD);

  slice_buffer u_src (
    .clk   (clk),
    .we    (ld_fire),
    .waddr (ld_idx[IDX_W-1:0]),
    .wdata (bus.ld_data),
    .raddr (rd_idx[IDX_W-1:0]),
    .rdata (src_rdata)
  );

  slice_buffer u_dst (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_idx[IDX_W-1:0]),
    .wdata (bus.perm_out),
    .raddr (ul_raddr),
    .rdata (dst_rdata)
  );

  assign bus.perm_in = ((state == RUN) && (rd_idx != IDX_FULL)) ? src_rdata : '0;

  // NOTE: all state uses non-blocking assignments; where two assignments to the same
  // register can both execute, the later one in this block takes effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ld_idx          <= '0;
      rd_idx          <= '0;
      wr_idx          <= '0;
      ul_idx          <= '0;
      bus.ld_ready    <= 1'b0;
      bus.perm_start  <= 1'b0;
      bus.ul_valid    <= 1'b0;
      bus.ul_data     <= '0;
      bus.done        <= 1'b0;
      bus.err_overrun <= 1'b0;
      bus.err_short   <= 1'b0;
    end else begin
      bus.done <= 1'b0;

      if (rd_fire) rd_idx <= rd_idx + 1'b1;
      if ((state == RUN) && bus.perm_read) begin
        bus.perm_start <= 1'b0;
        if (rd_idx == IDX_FULL) bus.err_overrun <= 1'b1;
      end
      if ((state == RUN) && bus.perm_total_ready && (wr_idx != IDX_FULL)) bus.err_short <= 1'b1;

      case (state)
        IDLE: begin
          bus.ld_ready <= 1'b1;
          if (ld_fire) begin
            ld_idx <= ld_idx + 1'b1;
            state  <= LOAD;
          end
        end

        LOAD: begin
          if (ld_fire) begin
            ld_idx <= ld_idx + 1'b1;
            if (ld_idx == IDX_LAST) begin
              state          <= RUN;
              ld_idx         <= '0;
              rd_idx         <= '0;
              wr_idx         <= '0;
              bus.ld_ready   <= 1'b0;
              bus.perm_start <= 1'b1;
            end
          end
        end

        RUN: begin
          if (wr_fire) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_idx == IDX_LAST) begin
              state        <= UNLOAD;
              bus.ul_valid <= 1'b1;
              bus.ul_data  <= dst_rdata;
            end
          end
        end

        UNLOAD: begin
          if (ul_fire) begin
            if (ul_idx == IDX_LAST) begin
              state        <= IDLE;
              ul_idx       <= '0;
              bus.ul_valid <= 1'b0;
              bus.done     <= 1'b1;
              bus.ld_ready <= 1'b1;
            end else begin
              ul_idx      <= ul_idx + 1'b1;
              bus.ul_data <= dst_rdata;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_permutation_host.sv
// Self-checking bench for permutation_host: a behavioural core model with a reply
// queue drives the slice stream, and every slice is checked against the loaded data.
module tb_permutation_host;
  import permutation_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  permutation_host_if bus ();

  permutation_host dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  slice_t src_data [DEPTH];

  typedef struct {
    int     due;
    slice_t val;
  } pend_t;

  task automatic clear_inputs();
    bus.ld_valid         = 1'b0;
    bus.ld_data          = '0;
    bus.perm_read        = 1'b0;
    bus.perm_ready       = 1'b0;
    bus.perm_out         = '0;
    bus.perm_total_ready = 1'b0;
    bus.ul_ready         = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_src(input bit ramp);
    for (int i = 0; i < DEPTH; i++)
      src_data[i] = ramp ? slice_t'(i) : slice_t'($urandom);
  endtask

  // Starts on a negedge, ends on the negedge after the 64th load handshake.
  task automatic do_load();
    int i = 0;
    int guard = 0;
    while (i < DEPTH && guard < 500) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = src_data[i];
      if (bus.ld_ready === 1'b1) i++;
      guard++;
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    checks++;
    if (i != DEPTH) $display("FAIL load_timeout: accepted %0d slices, required %0d", i, DEPTH);
    if (i != DEPTH) errors++;
    checks++;
    if (bus.ld_ready !== 1'b0 || bus.perm_start !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: ld_ready=%b perm_start=%b, required 0 1", bus.ld_ready, bus.perm_start);
    end
  endtask

  // Core model. mode 0: read every cycle, reply 3 cycles later.
  // mode 1: random reads/replies overlapping, plus one extra (65th) read.
  // mode 2: like mode 0, but raises perm_total_ready after 40 captures.
  task automatic run_core(input int mode);
    pend_t  q[$];
    pend_t  p;
    slice_t exp;
    int     t = 0, reads = 0, caps = 0;
    bit     rd, rdy, tot;
    bit     over_done = 0, short_done = 0, chk_ovr = 0, chk_short = 0;

    checks++;
    if (bus.err_overrun !== 1'b0 || bus.err_short !== 1'b0) begin
      errors++;
      $display("FAIL err_initial: overrun=%b short=%b, required 0 0", bus.err_overrun, bus.err_short);
    end

    while (caps < DEPTH && t < 3000) begin
      if (chk_ovr) begin
        chk_ovr = 0;
        checks++;
        if (bus.err_overrun !== 1'b1) begin
          errors++;
          $display("FAIL err_overrun: got %b required 1", bus.err_overrun);
        end
      end
      if (chk_short) begin
        chk_short = 0;
        checks++;
        if (bus.err_short !== 1'b1 || bus.ul_valid !== 1'b0 || bus.ld_ready !== 1'b0) begin
          errors++;
          $display("FAIL err_short: err_short=%b ul_valid=%b ld_ready=%b, required 1 0 0",
                   bus.err_short, bus.ul_valid, bus.ld_ready);
        end
      end

      checks++;
      if (bus.perm_start !== (reads == 0)) begin
        errors++;
        $display("FAIL perm_start: cycle %0d got %b required %b", t, bus.perm_start, reads == 0);
      end

      rd = 0; rdy = 0; tot = 0;
      case (mode)
        1: begin
          rd  = (reads < DEPTH || !over_done) && ($urandom_range(0, 2) != 0);
          rdy = (q.size() > 0) && (caps < DEPTH - 1 || over_done) && ($urandom_range(0, 2) != 0);
        end
        2: begin
          rd = reads < DEPTH;
          if (caps == 40 && !short_done) begin
            tot = 1; short_done = 1; chk_short = 1;
          end else begin
            rdy = (q.size() > 0) && (q[0].due <= t);
          end
        end
        default: begin
          rd  = reads < DEPTH;
          rdy = (q.size() > 0) && (q[0].due <= t);
        end
      endcase

      if (rdy) begin
        p = q.pop_front();
        bus.perm_out = p.val;
        caps++;
      end else begin
        bus.perm_out = slice_t'($urandom);
      end

      if (rd) begin
        exp = (reads < DEPTH) ? src_data[reads] : '0;
        checks++;
        if (bus.perm_in !== exp) begin
          errors++;
          $display("FAIL perm_in: read %0d got %h required %h", reads, bus.perm_in, exp);
        end
        if (reads < DEPTH) begin
          p.due = t + 3;
          p.val = ~exp;
          q.push_back(p);
        end else begin
          over_done = 1;
          chk_ovr   = 1;
        end
        reads++;
      end

      bus.perm_read        = rd;
      bus.perm_ready       = rdy;
      bus.perm_total_ready = tot;
      @(negedge clk);
      t++;
    end
    bus.perm_read        = 1'b0;
    bus.perm_ready       = 1'b0;
    bus.perm_total_ready = 1'b0;
    checks++;
    if (caps != DEPTH) begin
      errors++;
      $display("FAIL core_timeout: captures %0d required %0d", caps, DEPTH);
    end
  endtask

  // Expects UNLOAD to be active on entry; keeps perm_ready high with junk data,
  // which must not disturb the captured slices.
  task automatic do_unload(input bit toggle, input string name);
    int k = 0, t = 0;
    bit phase = 1;
    bit rdy;
    slice_t exp;
    while (k < DEPTH && t < 500) begin
      exp = ~src_data[k];
      checks++;
      if (bus.ul_valid !== 1'b1 || bus.ul_data !== exp || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL %s: slice %0d ul_valid=%b ul_data=%h done=%b, required 1 %h 0",
                 name, k, bus.ul_valid, bus.ul_data, bus.done, exp);
        break;
      end
      rdy = toggle ? phase : 1'b1;
      phase = ~phase;
      bus.ul_ready   = rdy;
      bus.perm_ready = 1'b1;
      bus.perm_out   = slice_t'($urandom);
      if (rdy) k++;
      @(negedge clk);
      t++;
    end
    bus.ul_ready   = 1'b0;
    bus.perm_ready = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.ul_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: done=%b ul_valid=%b after %0d handshakes, required 1 0",
               name, bus.done, bus.ul_valid, k);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: done=%b ld_ready=%b, required 0 1", name, bus.done, bus.ld_ready);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ld_ready !== 1'b0 || bus.perm_start !== 1'b0 || bus.perm_in !== '0 ||
        bus.ul_valid !== 1'b0 || bus.ul_data !== '0 || bus.done !== 1'b0 ||
        bus.err_overrun !== 1'b0 || bus.err_short !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ld_ready=%b perm_start=%b perm_in=%h ul_valid=%b ul_data=%h done=%b errs=%b%b",
               bus.ld_ready, bus.perm_start, bus.perm_in, bus.ul_valid, bus.ul_data,
               bus.done, bus.err_overrun, bus.err_short);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: ld_ready=%b required 1", bus.ld_ready);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    fill_src(1'b1);
    do_load();
    run_core(0);
    do_unload(1'b0, "basic_unload");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    fill_src(1'b0);
    do_load();
    run_core(1);
    do_unload(1'b0, "b2b_unload");
  endtask

  task automatic test_short();
    apply_reset();
    fill_src(1'b0);
    do_load();
    run_core(2);
    do_unload(1'b0, "short_unload");
  endtask

  task automatic test_unload_stall();
    apply_reset();
    fill_src(1'b0);
    do_load();
    run_core(0);
    do_unload(1'b1, "stall_unload");
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    fill_src(1'b0);
    do_load();
    for (int c = 0; c < 10; c++) begin
      bus.perm_read        = 1'b1;
      bus.perm_total_ready = (c == 5);
      @(negedge clk);
    end
    bus.perm_read        = 1'b0;
    bus.perm_total_ready = 1'b0;
    checks++;
    if (bus.err_short !== 1'b1 || bus.perm_in !== src_data[10]) begin
      errors++;
      $display("FAIL midrun_state: err_short=%b perm_in=%h, required 1 %h",
               bus.err_short, bus.perm_in, src_data[10]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.perm_start !== 1'b0 || bus.err_short !== 1'b0 || bus.err_overrun !== 1'b0 ||
        bus.ul_valid !== 1'b0 || bus.perm_in !== '0) begin
      errors++;
      $display("FAIL midrun_reset: perm_start=%b errs=%b%b ul_valid=%b perm_in=%h, required 0 00 0 0",
               bus.perm_start, bus.err_overrun, bus.err_short, bus.ul_valid, bus.perm_in);
    end
    @(negedge clk);
    checks++;
    if (bus.ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_idle: ld_ready=%b required 1", bus.ld_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_short();
    test_unload_stall();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
